// File: rtl/btn_conditioner.sv
// Two-channel push-button conditioner: 2-flop sync, debounce FSM, press strobes, conflict detect.
// Optional auto-repeat while held is enabled by defining BTN_CONDITIONER_AUTOREPEAT_EN.

module btn_channel #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic hit
);
    typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_t;

    if ((64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES)) begin : g_bad_cnt_w
        $error("CNT_W too narrow for DEBOUNCE_CYCLES");
    end
    if (REPEAT_CYCLES < 1) begin : g_bad_repeat
        $error("REPEAT_CYCLES must be positive");
    end

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [1:0]         sync_q;
    logic               level_q, level_d, hit_q, hit_d;
    logic               btn_s;

    assign btn_s   = sync_q[1];
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign level   = level_q;
    assign hit     = hit_q;

`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);
    logic [RPT_W-1:0] rpt_q, rpt_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rpt_q <= '0;
        else     rpt_q <= rpt_d;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sync_q  <= '0;
            level_q <= 1'b0;
            hit_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sync_q  <= {sync_q[0], btn_raw};
            level_q <= level_d;
            hit_q   <= hit_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        hit_d   = 1'b0;
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
        rpt_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                level_d = 1'b0;
                if (btn_s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            PRESS_WAIT: begin
                if (!btn_s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    hit_d   = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            HELD: begin
                if (!btn_s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CNT_W'(1);
                end
`ifdef BTN_CONDITIONER_AUTOREPEAT_EN
                // Repeat counter only runs while staying in HELD; any exit clears it.
                else if (rpt_q >= RPT_W'(REPEAT_CYCLES - 1)) begin
                    hit_d = 1'b1;
                    rpt_d = '0;
                end else begin
                    rpt_d = (rpt_q == '1) ? rpt_q : rpt_q + 1'b1;
                end
`endif
            end
            RELEASE_WAIT: begin
                if (btn_s) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q >= CNT_W'(DEBOUNCE_CYCLES)) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end
endmodule

module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 19,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_east,
    input  logic btn_west,
    output logic east_pulse,
    output logic west_pulse,
    output logic east_level,
    output logic west_level,
    output logic conflict
);
    localparam int NUM_CH = 2;

    logic [NUM_CH-1:0] btn_raw, level, hit;

    assign btn_raw = {btn_west, btn_east};

    for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_ch
        btn_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .REPEAT_CYCLES  (REPEAT_CYCLES)
        ) u_ch (
            .clk    (clk),
            .rst    (reset),
            .btn_raw(btn_raw[ch]),
            .level  (level[ch]),
            .hit    (hit[ch])
        );
    end

    // Simultaneous acceptance is ambiguous downstream, so neither strobe is passed on.
    assign east_pulse = hit[0] & ~hit[1];
    assign west_pulse = hit[1] & ~hit[0];
    assign conflict   = &hit;
    assign east_level = level[0];
    assign west_level = level[1];
endmodule
